mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares one external memory channel between NUM_CONSUMERS requesters (fetchers or LSUs), serialising their read/write requests with one outstanding transaction at a time. It sits between a group of cores and a single memory port wherever the memory side offers fewer channels than there are consumers. It uses the same valid/ready request-and-release handshake as the existing memory channels. Grant order is strictly fair: the most recently served consumer gets lowest priority next time.

## Interface
Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 16, memory data width
- NUM_CONSUMERS, 4, number of requesters (≥1)
- WRITE_ENABLE, 1, 0 = read-only; write path disabled

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read data valid / request accepted
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
- consumer_write_ready  out  NUM_CONSUMERS  write done
- mem_read_valid  out  1;  mem_read_address  out  ADDR_BITS;  mem_read_ready  in  1;  mem_read_data  in  DATA_BITS
- mem_write_valid  out  1;  mem_write_address  out  ADDR_BITS;  mem_write_data  out  DATA_BITS;  mem_write_ready  in  1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- State machine: IDLE, READ_WAIT, WRITE_WAIT, RELEASE. Registers: state, grant (index), rr_ptr (index of highest-priority consumer).
- IDLE: scan consumers rr_ptr, rr_ptr+1, … mod NUM_CONSUMERS; first i with read_valid or write_valid (write only if WRITE_ENABLE=1) wins. Load grant←i.
  - If read_valid[i]: mem_read_valid←1, mem_read_address←addr[i], → READ_WAIT. Read has priority over write for the same consumer; the write is served on a later grant.
  - Else: mem_write_valid←1, mem_write_address/data←consumer i's values, → WRITE_WAIT.
  - No request: stay in IDLE.
- READ_WAIT: when mem_read_ready=1: mem_read_valid←0, consumer_read_data[grant]←mem_read_data, consumer_read_ready[grant]←1, → RELEASE.
- WRITE_WAIT: when mem_write_ready=1: mem_write_valid←0, consumer_write_ready[grant]←1, → RELEASE.
- RELEASE: when consumer_read_valid[grant]=0 and consumer_write_valid[grant]=0: clear that consumer's ready outputs, rr_ptr←(grant+1) mod NUM_CONSUMERS, → IDLE. Otherwise hold ready high.
- consumer_read_data[i] holds its last value until overwritten by the next read to i; it is not cleared on RELEASE.
- Consumer drops valid during READ_WAIT/WRITE_WAIT: the memory transaction still completes. Ready pulses high for exactly one cycle in RELEASE, then the arbiter returns to IDLE.
- WRITE_ENABLE=0: write requests are ignored. consumer_write_ready and mem_write_valid are held 0, and WRITE_WAIT is unreachable.
- Address latched on grant; later changes to consumer address are ignored until next grant.

## Timing
- Reset (sync): state=IDLE, rr_ptr=0, grant=0. All outputs 0: mem_*_valid, mem addresses/data, consumer_*_ready, consumer_read_data, busy. An in-flight memory transaction is abandoned (valid drops on the reset edge).
- Request sampled at edge k → mem_*_valid high after edge k.
- Memory ready seen at edge m → consumer ready high after edge m.
- Consumer valid low at edge r → ready low and IDLE after edge r. Earliest next grant is edge r+1.
- Minimum occupancy per transaction with a zero-wait memory: 3 cycles (grant, complete, release).
- Never more than one of mem_read_valid / mem_write_valid high. At most one consumer ready bit high at any time.
- busy registered alongside state.

## Test plan
- Single read: N=4, consumer 2 reads addr 0x10, memory returns 0xBEEF with 1-cycle ready → mem_read_address=0x10; consumer_read_ready[2]=1 with data 0xBEEF; drop valid → IDLE, rr_ptr=3.
- Fairness: all 4 consumers hold read_valid continuously from reset → grants in order 0,1,2,3,0. No consumer is served twice before all others are served once.
- Write: consumer 1 writes 0x55AA to 0x3C; memory ready after 4 wait cycles → mem_write_* stable for all 4 wait cycles; consumer_write_ready[1] rises the cycle after mem_write_ready; no read activity.
- Read/write same consumer: consumer 0 asserts both → read served first; after release and re-grant, write served; mem_read_valid and mem_write_valid are never high together.
- Reset mid-op: assert reset during READ_WAIT → next cycle all outputs 0, busy=0, rr_ptr=0. A fresh request from consumer 3 is then served normally.
- WRITE_ENABLE=0, NUM_CONSUMERS=1: write_valid asserted → no mem_write_valid and no write_ready ever. Repeated reads wrap rr_ptr to 0 and each completes.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that serialises read/write requests from
// NUM_CONSUMERS requesters onto a single memory channel, one transaction at a
// time. The most recently served consumer becomes lowest priority next time.
module mem_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,

    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,

    output logic                               busy
);

    localparam int unsigned      IDX_W    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);
    localparam bit               WR_EN    = (WRITE_ENABLE != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic                   busy_q;
    logic                   mem_read_valid_q;
    logic                   mem_write_valid_q;
    logic [ADDR_BITS-1:0]   mem_read_address_q;
    logic [ADDR_BITS-1:0]   mem_write_address_q;
    logic [DATA_BITS-1:0]   mem_write_data_q;
    logic [NUM_CONSUMERS-1:0] read_ready_q;
    logic [NUM_CONSUMERS-1:0] write_ready_q;
    logic [DATA_BITS-1:0]   read_data_q [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0] wr_req_c;
    logic [NUM_CONSUMERS-1:0] any_req_c;
    logic [ADDR_BITS-1:0]   rd_addr_c [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]   wr_addr_c [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   wr_data_c [NUM_CONSUMERS];
    logic                   found_c;
    logic [IDX_W-1:0]       win_c;
    logic [IDX_W-1:0]       idx_c;

    // Write requests are invisible when the write path is disabled
    assign wr_req_c  = consumer_write_valid & {NUM_CONSUMERS{WR_EN}};
    assign any_req_c = consumer_read_valid | wr_req_c;

    // Unpack the flat per-consumer buses and pack the read-data registers
    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_lanes
        assign rd_addr_c[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr_c[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data_c[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = read_data_q[i];
    end

    // Round-robin scan starting at rr_ptr; first requester wins
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            idx_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_CONSUMERS);
            if (!found_c && any_req_c[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // Served consumer drops to lowest priority
    assign rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            rr_ptr_q            <= '0;
            busy_q              <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                read_data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        grant_q <= win_c;
                        if (consumer_read_valid[win_c]) begin
                            mem_read_valid_q   <= 1'b1;
                            mem_read_address_q <= rd_addr_c[win_c];
                            busy_q             <= 1'b1;
                            state_q            <= READ_WAIT;
                        end else if (WR_EN) begin
                            mem_write_valid_q   <= 1'b1;
                            mem_write_address_q <= wr_addr_c[win_c];
                            mem_write_data_q    <= wr_data_c[win_c];
                            busy_q              <= 1'b1;
                            state_q             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid_q      <= 1'b0;
                        read_data_q[grant_q]  <= mem_read_data;
                        read_ready_q[grant_q] <= 1'b1;
                        state_q               <= RELEASE;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid_q      <= 1'b0;
                        write_ready_q[grant_q] <= 1'b1;
                        state_q                <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!consumer_read_valid[grant_q] && !wr_req_c[grant_q]) begin
                        read_ready_q  <= '0;
                        write_ready_q <= '0;
                        rr_ptr_q      <= rr_ptr_d;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 4-consumer read/write instance and a
// 1-consumer read-only instance, both driven from one stimulus process.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    c_rv  = '0;
    logic [N-1:0]    c_wv  = '0;
    logic [N*AW-1:0] c_ra  = '0;
    logic [N*AW-1:0] c_wa  = '0;
    logic [N*DW-1:0] c_wd  = '0;
    logic [N-1:0]    c_rr;
    logic [N-1:0]    c_wr;
    logic [N*DW-1:0] c_rd;
    logic            m_rv;
    logic [AW-1:0]   m_ra;
    logic            m_rr    = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_wv;
    logic [AW-1:0]   m_wa;
    logic [DW-1:0]   m_wd;
    logic            m_wr    = 1'b0;
    logic            busy;

    logic            d1_reset = 1'b1;
    logic [0:0]      d1_c_rv  = '0;
    logic [0:0]      d1_c_wv  = '0;
    logic [AW-1:0]   d1_c_ra  = '0;
    logic [AW-1:0]   d1_c_wa  = 8'h77;
    logic [DW-1:0]   d1_c_wd  = 16'h1234;
    logic [0:0]      d1_c_rr;
    logic [0:0]      d1_c_wr;
    logic [DW-1:0]   d1_c_rd;
    logic            d1_m_rv;
    logic [AW-1:0]   d1_m_ra;
    logic            d1_m_rr    = 1'b0;
    logic [DW-1:0]   d1_m_rdata = '0;
    logic            d1_m_wv;
    logic [AW-1:0]   d1_m_wa;
    logic [DW-1:0]   d1_m_wd;
    logic            d1_m_wr    = 1'b1;
    logic            d1_busy;

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) u_dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rdata),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr),
        .busy(busy)
    );

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(1), .WRITE_ENABLE(0)) u_dut1 (
        .clk(clk), .reset(d1_reset),
        .consumer_read_valid(d1_c_rv), .consumer_read_address(d1_c_ra),
        .consumer_read_ready(d1_c_rr), .consumer_read_data(d1_c_rd),
        .consumer_write_valid(d1_c_wv), .consumer_write_address(d1_c_wa),
        .consumer_write_data(d1_c_wd), .consumer_write_ready(d1_c_wr),
        .mem_read_valid(d1_m_rv), .mem_read_address(d1_m_ra),
        .mem_read_ready(d1_m_rr), .mem_read_data(d1_m_rdata),
        .mem_write_valid(d1_m_wv), .mem_write_address(d1_m_wa),
        .mem_write_data(d1_m_wd), .mem_write_ready(d1_m_wr),
        .busy(d1_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          id;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        mq[$];
    exp_t        cq[$];
    logic [15:0] q1[$];
    int          tests = 0;
    int          fails = 0;

    logic [15:0] mem_model [256];
    int          mem_wait = 0;
    int          rcnt = 0;
    int          wcnt = 0;
    int          rd_left [N];
    int          wr_left [N];
    logic [7:0]  rd_addr [N];
    logic [7:0]  wr_addr [N];
    logic [15:0] wr_dat  [N];
    int          d1_left = 0;
    logic [7:0]  d1_addr = 8'h40;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit agents_idle();
        for (int i = 0; i < N; i++) begin
            if (rd_left[i] != 0 || wr_left[i] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_rd(input int id, input logic [7:0] a, input logic [15:0] d);
        mq.push_back('{wr: 1'b0, id: id, addr: a, data: 16'h0});
        cq.push_back('{wr: 1'b0, id: id, addr: a, data: d});
    endtask

    task automatic push_wr(input int id, input logic [7:0] a, input logic [15:0] d);
        mq.push_back('{wr: 1'b1, id: id, addr: a, data: d});
        cq.push_back('{wr: 1'b1, id: id, addr: a, data: d});
    endtask

    // One clock step: memory responders, then consumer agents, for both DUTs
    task automatic tick();
        @(posedge clk);
        #1;
        m_rr = 1'b0;
        m_wr = 1'b0;
        if (m_rv) begin
            if (rcnt >= mem_wait) begin
                m_rr = 1'b1; m_rdata = mem_model[m_ra]; rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
        if (m_wv) begin
            if (wcnt >= mem_wait) begin
                m_wr = 1'b1; mem_model[m_wa] = m_wd; wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
        for (int i = 0; i < N; i++) begin
            if (c_rr[i] || c_wr[i]) begin
                if (c_rr[i] && c_rv[i]) rd_left[i]--;
                if (c_wr[i] && c_wv[i]) wr_left[i]--;
                c_rv[i] = 1'b0;
                c_wv[i] = 1'b0;
            end else begin
                if (rd_left[i] > 0) c_rv[i] = 1'b1;
                if (wr_left[i] > 0) c_wv[i] = 1'b1;
            end
            c_ra[i*AW +: AW] = rd_addr[i];
            c_wa[i*AW +: AW] = wr_addr[i];
            c_wd[i*DW +: DW] = wr_dat[i];
        end
        d1_m_rr    = d1_m_rv;
        d1_m_rdata = 16'h7000 | 16'(d1_m_ra);
        if (d1_c_rr[0]) begin
            if (d1_c_rv[0]) begin d1_left--; d1_addr = d1_addr + 8'd1; end
            d1_c_rv = 1'b0;
        end else if (d1_left > 0) d1_c_rv = 1'b1;
        d1_c_ra = d1_addr;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n < budget && !(mq.size() == 0 && cq.size() == 0 && !busy && agents_idle())) begin
            tick();
            n++;
        end
        chk({name, "_completes"}, 64'(n < budget), 64'd1);
    endtask

    // Monitor: pops expectations when the DUT presents activity
    logic            p_mrv = 1'b0, p_mwv = 1'b0, p_mrr = 1'b0, p_mwr = 1'b0;
    logic [AW-1:0]   p_ra = '0, p_wa = '0;
    logic [DW-1:0]   p_wd = '0;
    logic [N-1:0]    p_rr = '0, p_wr = '0;
    logic [N-1:0]    rise, ev;
    logic            d1_p_rr = 1'b0;
    exp_t            e;

    always @(negedge clk) begin
        if (!reset) begin
            chk("one_mem_valid", 64'(m_rv & m_wv), 64'd0);
            chk("ready_onehot0", 64'($onehot0({c_rr, c_wr})), 64'd1);
            if (m_rv && p_mrv) chk("mem_read_addr_stable", 64'(m_ra), 64'(p_ra));
            if (m_wv && p_mwv) begin
                chk("mem_write_addr_stable", 64'(m_wa), 64'(p_wa));
                chk("mem_write_data_stable", 64'(m_wd), 64'(p_wd));
            end
            if ((m_rv && !p_mrv) || (m_wv && !p_mwv)) begin
                if (mq.size() == 0) chk("unexpected_mem_request", 64'd1, 64'd0);
                else begin
                    e = mq.pop_front();
                    chk("mem_request_is_write", 64'(m_wv), 64'(e.wr));
                    if (e.wr) begin
                        chk("mem_write_addr", 64'(m_wa), 64'(e.addr));
                        chk("mem_write_data", 64'(m_wd), 64'(e.data));
                    end else chk("mem_read_addr", 64'(m_ra), 64'(e.addr));
                end
            end
            rise = (c_rr & ~p_rr) | (c_wr & ~p_wr);
            if (rise != '0) begin
                if (cq.size() == 0) chk("unexpected_consumer_ready", 64'(rise), 64'd0);
                else begin
                    e  = cq.pop_front();
                    ev = N'(1) << e.id;
                    if (e.wr) begin
                        chk("write_ready_vec", 64'(c_wr & ~p_wr), 64'(ev));
                        chk("write_ready_after_mem_ready", 64'(p_mwr), 64'd1);
                    end else begin
                        chk("read_ready_vec", 64'(c_rr & ~p_rr), 64'(ev));
                        chk("read_data", 64'(c_rd[e.id*DW +: DW]), 64'(e.data));
                        chk("read_ready_after_mem_ready", 64'(p_mrr), 64'd1);
                    end
                end
            end
        end
        if (!d1_reset) begin
            chk("d1_no_mem_write", 64'(d1_m_wv), 64'd0);
            chk("d1_no_write_ready", 64'(d1_c_wr), 64'd0);
            if (d1_c_rr[0] && !d1_p_rr) begin
                if (q1.size() == 0) chk("d1_unexpected_ready", 64'd1, 64'd0);
                else chk("d1_read_data", 64'(d1_c_rd), 64'(q1.pop_front()));
            end
        end
        p_mrv = m_rv; p_mwv = m_wv; p_mrr = m_rr; p_mwr = m_wr;
        p_ra = m_ra; p_wa = m_wa; p_wd = m_wd;
        p_rr = c_rr; p_wr = c_wr; d1_p_rr = d1_c_rr[0];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'h0;
        for (int i = 0; i < N; i++) begin
            rd_left[i] = 0; wr_left[i] = 0;
            rd_addr[i] = '0; wr_addr[i] = '0; wr_dat[i] = '0;
        end
        mem_model[8'h10] = 16'hBEEF;
        mem_model[8'h05] = 16'h0505;
        mem_model[8'h33] = 16'h3333;
        for (int i = 0; i < N; i++) mem_model[8'h20 + i] = 16'h1000 + 16'(i);

        // Read-only single-consumer instance runs in the background
        d1_left = 3;
        d1_c_wv = 1'b1;
        q1.push_back(16'h7040);
        q1.push_back(16'h7041);
        q1.push_back(16'h7042);

        repeat (3) tick();
        reset    = 1'b0;
        d1_reset = 1'b0;

        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_mem_valids", 64'({m_rv, m_wv}), 64'd0);
        chk("reset_ready", 64'({c_rr, c_wr}), 64'd0);
        chk("reset_read_data", 64'(c_rd), 64'd0);
        chk("reset_rr_ptr", 64'(u_dut.rr_ptr_q), 64'd0);

        // Single read from consumer 2
        rd_addr[2] = 8'h10; rd_left[2] = 1;
        push_rd(2, 8'h10, 16'hBEEF);
        wait_done("single_read", 50);
        chk("single_read_rr_ptr", 64'(u_dut.rr_ptr_q), 64'd3);
        chk("single_read_data_held", 64'(c_rd[2*DW +: DW]), 64'hBEEF);

        // Fairness from reset: all four request twice
        reset = 1'b1; tick(); reset = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_rd(i, 8'h20 + 8'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < N; i++) begin rd_addr[i] = 8'h20 + 8'(i); rd_left[i] = 2; end
        wait_done("fairness", 300);

        // Write with four memory wait cycles
        mem_wait = 4;
        wr_addr[1] = 8'h3C; wr_dat[1] = 16'h55AA; wr_left[1] = 1;
        push_wr(1, 8'h3C, 16'h55AA);
        wait_done("write", 80);
        chk("write_landed", 64'(mem_model[8'h3C]), 64'h55AA);
        chk("write_rr_ptr", 64'(u_dut.rr_ptr_q), 64'd2);

        // Read and write from the same consumer: read first
        mem_wait = 1;
        rd_addr[0] = 8'h05; wr_addr[0] = 8'h06; wr_dat[0] = 16'hA5A5;
        rd_left[0] = 1; wr_left[0] = 1;
        push_rd(0, 8'h05, 16'h0505);
        push_wr(0, 8'h06, 16'hA5A5);
        wait_done("read_then_write", 80);
        chk("rw_write_landed", 64'(mem_model[8'h06]), 64'hA5A5);

        // Reset while a read is outstanding
        mem_wait = 5;
        rd_addr[1] = 8'h11; rd_left[1] = 1;
        mq.push_back('{wr: 1'b0, id: 1, addr: 8'h11, data: 16'h0});
        n = 0;
        while (!m_rv && n < 20) begin tick(); n++; end
        chk("midop_read_issued", 64'(m_rv), 64'd1);
        tick();
        rd_left[1] = 0; c_rv[1] = 1'b0;
        reset = 1'b1;
        tick();
        chk("midop_busy", 64'(busy), 64'd0);
        chk("midop_mem_valids", 64'({m_rv, m_wv}), 64'd0);
        chk("midop_mem_addr_data", 64'({m_ra, m_wa, m_wd}), 64'd0);
        chk("midop_ready", 64'({c_rr, c_wr}), 64'd0);
        chk("midop_read_data", 64'(c_rd), 64'd0);
        chk("midop_rr_ptr", 64'(u_dut.rr_ptr_q), 64'd0);
        reset = 1'b0;
        mem_wait = 0;
        rd_addr[3] = 8'h33; rd_left[3] = 1;
        push_rd(3, 8'h33, 16'h3333);
        wait_done("after_reset_read", 50);
        chk("after_reset_rr_ptr", 64'(u_dut.rr_ptr_q), 64'd0);

        // Read-only instance: all reads done, pointer wrapped
        n = 0;
        while ((q1.size() != 0 || d1_left != 0 || d1_busy) && n < 100) begin tick(); n++; end
        chk("d1_reads_complete", 64'(q1.size()), 64'd0);
        chk("d1_rr_ptr_wrap", 64'(u_dut1.rr_ptr_q), 64'd0);
        chk("scoreboard_empty", 64'(mq.size() + cq.size()), 64'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
